// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: AMM bus geometry, command struct and the pattern helpers shared with compare_block
package rtl_settings_pkg;
  localparam int AMM_DATA_W  = 64;
  localparam int AMM_ADDR_W  = 32;
  localparam int AMM_BURST_W = 8;
  localparam int BE_W        = AMM_DATA_W / 8;
  localparam int OFF_W       = $clog2(BE_W);
  localparam int WC_W        = AMM_BURST_W - 1;
  localparam string ADDR_TYPE = "BYTE";
  localparam bit BYTE_ADDR   = (ADDR_TYPE == "BYTE");
  typedef enum logic {FIX_DATA = 1'b0, RND_DATA = 1'b1} data_mode_t;
  typedef enum logic [2:0] {IDLE_S, WRITE_S, RD_WAIT_S, READ_S, STOP_S} trans_state_t;
  // words_count is one bit narrower than burstcount so words_count+1 never overflows
  typedef struct packed {
    logic [AMM_ADDR_W-1:0] start_addr;
    logic [WC_W-1:0]       words_count;
    logic [OFF_W-1:0]      start_off;
    logic [OFF_W-1:0]      end_off;
    data_mode_t            data_mode;
    logic [7:0]            data_ptrn;
  } cmp_struct_t;
  function automatic logic [BE_W-1:0] byteenable_ptrn(input logic first, input logic [OFF_W-1:0] start_off,
                                                      input logic last, input logic [OFF_W-1:0] end_off);
    return (first ? {BE_W{1'b1}} << start_off : {BE_W{1'b1}}) &
           (last ? {BE_W{1'b1}} >> (OFF_W'(BE_W - 1) - end_off) : {BE_W{1'b1}});
  endfunction
  function automatic logic [7:0] lfsr8_next(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction
endpackage

// File: rtl/amm_wr_data_gen.sv
// amm_wr_data_gen: per-beat write pattern and byteenable, advancing only on accepted beats
module amm_wr_data_gen
  import rtl_settings_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [7:0]            ptrn_i,
  input  logic                  adv_i,
  input  data_mode_t            mode_i,
  input  logic [WC_W-1:0]       wc_i,
  input  logic [OFF_W-1:0]      start_off_i,
  input  logic [OFF_W-1:0]      end_off_i,
  output logic [AMM_DATA_W-1:0] writedata_o,
  output logic [BE_W-1:0]       byteenable_o,
  output logic                  last_o
);
  logic [7:0]      r_ptrn;
  logic [WC_W-1:0] r_beat;
  logic            w_first;
  assign w_first      = r_beat == '0;
  assign last_o       = r_beat == wc_i;
  assign writedata_o  = {BE_W{r_ptrn}};
  assign byteenable_o = BYTE_ADDR ? byteenable_ptrn(w_first, start_off_i, last_o, end_off_i) : '1;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_ptrn <= '0;
      r_beat <= '0;
    end else if (load_i) begin
      r_ptrn <= ptrn_i;
      r_beat <= '0;
    end else if (adv_i) begin
      r_ptrn <= (mode_i == RND_DATA) ? lfsr8_next(r_ptrn) : r_ptrn;
      r_beat <= r_beat + WC_W'(1);
    end
endmodule

// File: rtl/amm_transmitter.sv
// amm_transmitter: Avalon-MM write-then-read burst master feeding compare_block.
// Define TRANSMITTER_STAT_EN for saturating write-beat / read-command counters.
module amm_transmitter
  import rtl_settings_pkg::*;
#(
  parameter int MAX_RD_OUTST = 4,
  parameter int CRED_W       = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   test_start_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  cmp_struct_t            cmd_struct_i,
  output logic [AMM_ADDR_W-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [AMM_DATA_W-1:0]  writedata_o,
  output logic [BE_W-1:0]        byteenable_o,
  output logic [AMM_BURST_W-1:0] burstcount_o,
  input  logic                   waitrequest_i,
  output logic                   cmp_en_o,
  output cmp_struct_t            cmp_struct_o,
  input  logic                   cmp_done_i,
  input  logic                   cmp_error_i,
  output logic                   trans_busy_o,
  output logic [31:0]            wr_words_cnt_o,
  output logic [31:0]            rd_cmd_cnt_o
);
  trans_state_t r_state, w_next;
  cmp_struct_t r_cmd;
  logic [CRED_W-1:0] r_cred;
  logic r_err, r_cmp_en, r_ready_en;
  logic w_err, w_cmd_acc, w_wr_acc, w_rd_acc, w_last, w_inc, w_dec;
  logic [AMM_DATA_W-1:0] w_wdata;
  logic [BE_W-1:0] w_be;
  // an error seen mid-transfer is remembered until the FSM parks in STOP_S
  assign w_err        = cmp_error_i | r_err;
  assign cmd_ready_o  = r_ready_en && r_state == IDLE_S && !w_err;
  assign w_cmd_acc    = cmd_valid_i && cmd_ready_o;
  assign write_o      = r_state == WRITE_S;
  assign read_o       = r_state == READ_S;
  assign w_wr_acc     = write_o && !waitrequest_i;
  assign w_rd_acc     = read_o && !waitrequest_i;
  assign trans_busy_o = r_state != IDLE_S && r_state != STOP_S;
  assign address_o    = r_cmd.start_addr;
  assign burstcount_o = (write_o || read_o) ? AMM_BURST_W'(r_cmd.words_count) + AMM_BURST_W'(1) : '0;
  assign writedata_o  = write_o ? w_wdata : '0;
  assign byteenable_o = write_o ? w_be : '0;
  assign cmp_en_o     = r_cmp_en;
  assign cmp_struct_o = r_cmd;
  assign w_inc        = w_rd_acc && r_cred != CRED_W'(MAX_RD_OUTST);
  assign w_dec        = cmp_done_i && r_cred != '0;
  amm_wr_data_gen u_data_gen (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_i       (w_cmd_acc),
    .ptrn_i       (cmd_struct_i.data_ptrn),
    .adv_i        (w_wr_acc),
    .mode_i       (r_cmd.data_mode),
    .wc_i         (r_cmd.words_count),
    .start_off_i  (r_cmd.start_off),
    .end_off_i    (r_cmd.end_off),
    .writedata_o  (w_wdata),
    .byteenable_o (w_be),
    .last_o       (w_last)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE_S:    w_next = w_err ? STOP_S : w_cmd_acc ? WRITE_S : IDLE_S;
      WRITE_S:   w_next = (w_wr_acc && w_last) ? (w_err ? STOP_S : RD_WAIT_S) : WRITE_S;
      RD_WAIT_S: w_next = w_err ? STOP_S : (r_cred < CRED_W'(MAX_RD_OUTST)) ? READ_S : RD_WAIT_S;
      READ_S:    w_next = w_rd_acc ? (w_err ? STOP_S : IDLE_S) : READ_S;
      STOP_S:    w_next = test_start_i ? IDLE_S : STOP_S;
      default:   w_next = IDLE_S;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state    <= IDLE_S;
      r_cmd      <= '0;
      r_cred     <= '0;
      r_err      <= 1'b0;
      r_cmp_en   <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready_en <= 1'b1;
      r_cmp_en   <= w_rd_acc && !w_err;
      r_err      <= (r_state == STOP_S) ? 1'b0 : r_err | cmp_error_i;
      r_cred     <= test_start_i ? '0 : (w_inc && !w_dec) ? r_cred + CRED_W'(1) :
                    (w_dec && !w_inc) ? r_cred - CRED_W'(1) : r_cred;
      if (w_cmd_acc) r_cmd <= cmd_struct_i;
    end
`ifdef TRANSMITTER_STAT_EN
  logic [31:0] r_wr_cnt, r_rd_cnt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (test_start_i) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_acc && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (w_rd_acc && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  assign wr_words_cnt_o = r_wr_cnt;
  assign rd_cmd_cnt_o   = r_rd_cnt;
`else
  assign wr_words_cnt_o = '0;
  assign rd_cmd_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_amm_transmitter.sv
// tb_amm_transmitter: scenario tasks plus randomized bursts checked against a byte-level pattern model
module tb_amm_transmitter;
  import rtl_settings_pkg::*;
  logic clk_i = 1'b0, rst_n_i = 1'b0, test_start_i = 1'b0, cmd_valid_i = 1'b0;
  logic waitrequest_i = 1'b0, cmp_done_i = 1'b0, cmp_error_i = 1'b0;
  cmp_struct_t cmd_struct_i = '0;
  logic cmd_ready_o, read_o, write_o, cmp_en_o, trans_busy_o;
  logic [AMM_ADDR_W-1:0] address_o;
  logic [AMM_DATA_W-1:0] writedata_o;
  logic [BE_W-1:0] byteenable_o;
  logic [AMM_BURST_W-1:0] burstcount_o;
  cmp_struct_t cmp_struct_o;
  logic [31:0] wr_words_cnt_o, rd_cmd_cnt_o;
  int vectors = 0, miscompares = 0;
  amm_transmitter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .test_start_i(test_start_i), .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o), .cmd_struct_i(cmd_struct_i), .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .writedata_o(writedata_o), .byteenable_o(byteenable_o), .burstcount_o(burstcount_o),
    .waitrequest_i(waitrequest_i), .cmp_en_o(cmp_en_o), .cmp_struct_o(cmp_struct_o), .cmp_done_i(cmp_done_i),
    .cmp_error_i(cmp_error_i), .trans_busy_o(trans_busy_o), .wr_words_cnt_o(wr_words_cnt_o),
    .rd_cmd_cnt_o(rd_cmd_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end
  logic [AMM_DATA_W-1:0] obs_data[$], exp_data[$];
  logic [BE_W-1:0] obs_be[$], exp_be[$];
  logic [AMM_ADDR_W-1:0] obs_addr;
  logic [AMM_BURST_W-1:0] obs_wr_burst, obs_rd_burst;
  int obs_reads, obs_cmp_en, obs_wr_lat;
  cmp_struct_t obs_cmp;
  bit obs_hold_bad, obs_tmo;
  // pattern after k accepted beats: RND taps bits 7,5,4,3 into bit 0
  function automatic logic [7:0] model_ptrn(input logic [7:0] p0, input bit rnd, input int k);
    logic [7:0] p;
    p = p0;
    for (int i = 0; i < k; i++) if (rnd) p = {p[6:0], ^(p & 8'hB8)};
    return p;
  endfunction
  function automatic logic [BE_W-1:0] model_be(input cmp_struct_t c, input int k);
    logic [BE_W-1:0] m;
    for (int b = 0; b < BE_W; b++)
      m[b] = (k != 0 || b >= int'(c.start_off)) && (k != int'(c.words_count) || b <= int'(c.end_off));
    return m;
  endfunction
  function automatic void build_expected(input cmp_struct_t c);
    exp_data.delete();
    exp_be.delete();
    for (int k = 0; k <= int'(c.words_count); k++) begin
      exp_data.push_back({BE_W{model_ptrn(c.data_ptrn, c.data_mode == RND_DATA, k)}});
      exp_be.push_back(model_be(c, k));
    end
  endfunction
  function automatic cmp_struct_t mk_cmd(input logic [AMM_ADDR_W-1:0] a, input logic [WC_W-1:0] wc,
                                         input logic [OFF_W-1:0] so, input logic [OFF_W-1:0] eo,
                                         input data_mode_t m, input logic [7:0] p);
    cmp_struct_t c;
    c.start_addr = a; c.words_count = wc; c.start_off = so; c.end_off = eo; c.data_mode = m; c.data_ptrn = p;
    return c;
  endfunction
  task automatic pulse_start();
    test_start_i = 1'b1;
    @(posedge clk_i); #1;
    test_start_i = 1'b0;
  endtask
  task automatic pulse_done();
    cmp_done_i = 1'b1;
    @(posedge clk_i); #1;
    cmp_done_i = 1'b0;
  endtask
  // drives one command through the bus and records what the master did; err_beat -2 = error during read
  task automatic do_transfer(input cmp_struct_t c, input int stall_beat, input int stall_n,
                             input int err_beat, input int budget);
    int beat = 0, stalls = 0, cyc = 0, it = 0;
    bit acc = 0, post_rd = 0, done = 0, err_done = 0;
    logic [AMM_DATA_W-1:0] snap_d;
    logic [BE_W-1:0] snap_be;
    obs_data.delete(); obs_be.delete();
    obs_reads = 0; obs_cmp_en = 0; obs_hold_bad = 0; obs_wr_lat = -1;
    obs_cmp = '0; obs_addr = '0; obs_wr_burst = '0; obs_rd_burst = '0;
    snap_d = '0; snap_be = '0;
    cmd_struct_i = c;
    cmd_valid_i = 1'b1;
    while (!acc && cyc < budget) begin
      @(negedge clk_i); acc = cmd_ready_o;
      @(posedge clk_i); #1; cyc++;
    end
    cmd_valid_i = 1'b0;
    while (acc && !done && cyc < budget) begin
      waitrequest_i = write_o && beat == stall_beat && stalls < stall_n;
      cmp_error_i = !err_done && ((write_o && beat == err_beat) || (read_o && err_beat == -2));
      err_done |= cmp_error_i;
      @(negedge clk_i);
      if (cmp_en_o) begin obs_cmp_en++; obs_cmp = cmp_struct_o; end
      if (post_rd || (!trans_busy_o && !cmd_ready_o)) done = 1;
      if (write_o && obs_wr_lat < 0) obs_wr_lat = it;
      if (write_o && waitrequest_i) begin
        if (stalls == 0) begin snap_d = writedata_o; snap_be = byteenable_o; end
        else if (writedata_o !== snap_d || byteenable_o !== snap_be) obs_hold_bad = 1;
        stalls++;
      end else if (write_o) begin
        if (beat == 0) begin obs_addr = address_o; obs_wr_burst = burstcount_o; end
        obs_data.push_back(writedata_o);
        obs_be.push_back(byteenable_o);
        beat++;
      end
      if (read_o && !waitrequest_i) begin obs_reads++; obs_rd_burst = burstcount_o; post_rd = 1; end
      @(posedge clk_i); #1; cyc++; it++;
    end
    cmp_error_i = 1'b0;
    waitrequest_i = 1'b0;
    obs_tmo = !done;
  endtask
  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({cmd_ready_o, write_o, read_o, cmp_en_o, trans_busy_o} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b required 00000", {cmd_ready_o, write_o, read_o, cmp_en_o, trans_busy_o});
    end
    vectors++;
    if ({address_o, writedata_o, byteenable_o, burstcount_o, cmp_struct_o, wr_words_cnt_o, rd_cmd_cnt_o} !== '0) begin
      miscompares++; $display("FAIL reset_data: addr=%h data=%h be=%h bc=%h cmp=%h required all zero",
                              address_o, writedata_o, byteenable_o, burstcount_o, cmp_struct_o);
    end
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready: got %b required 1", cmd_ready_o); end
  endtask
  task automatic test_fix_burst();
    cmp_struct_t c;
    logic [31:0] ew, er;
    c = mk_cmd(32'h1000_0040, 3, 0, 7, FIX_DATA, 8'hA5);
    pulse_start();
    do_transfer(c, -1, 0, -1, 100);
    vectors++;
    if (obs_tmo || obs_data.size() != 4) begin miscompares++; $display("FAIL fix_beats: got %0d beats tmo=%0b required 4", obs_data.size(), obs_tmo); end
    for (int k = 0; k < obs_data.size(); k++) begin
      vectors++;
      if (obs_data[k] !== 64'hA5A5_A5A5_A5A5_A5A5 || obs_be[k] !== 8'hFF) begin
        miscompares++; $display("FAIL fix_beat%0d: got %h/%h required a5a5a5a5a5a5a5a5/ff", k, obs_data[k], obs_be[k]);
      end
    end
    vectors++;
    if (obs_wr_lat !== 0) begin miscompares++; $display("FAIL fix_wr_latency: got %0d required 0 extra cycles", obs_wr_lat); end
    vectors++;
    if (obs_addr !== 32'h1000_0040 || obs_wr_burst !== 8'd4) begin
      miscompares++; $display("FAIL fix_wr_hdr: got addr=%h bc=%0d required 10000040/4", obs_addr, obs_wr_burst);
    end
    vectors++;
    if (obs_reads !== 1 || obs_rd_burst !== 8'd4 || obs_cmp_en !== 1) begin
      miscompares++; $display("FAIL fix_read: got reads=%0d bc=%0d cmp_en=%0d required 1/4/1", obs_reads, obs_rd_burst, obs_cmp_en);
    end
    vectors++;
    if (obs_cmp !== c) begin miscompares++; $display("FAIL fix_cmp_struct: got %h required %h", obs_cmp, c); end
`ifdef TRANSMITTER_STAT_EN
    ew = 32'd4; er = 32'd1;
`else
    ew = 32'd0; er = 32'd0;
`endif
    vectors++;
    if (wr_words_cnt_o !== ew || rd_cmd_cnt_o !== er) begin
      miscompares++; $display("FAIL fix_stats: got wr=%0d rd=%0d required %0d/%0d", wr_words_cnt_o, rd_cmd_cnt_o, ew, er);
    end
    pulse_done();
  endtask
  task automatic test_rnd_stall();
    cmp_struct_t c;
    logic [7:0] ep[4];
    ep = '{8'h01, 8'h02, 8'h04, 8'h08};
    c = mk_cmd(32'h0000_2000, 3, 0, 7, RND_DATA, 8'h01);
    do_transfer(c, 1, 3, -1, 100);
    vectors++;
    if (obs_tmo || obs_data.size() != 4) begin miscompares++; $display("FAIL rnd_beats: got %0d beats tmo=%0b required 4", obs_data.size(), obs_tmo); end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      vectors++;
      if (obs_data[k] !== {BE_W{ep[k]}}) begin miscompares++; $display("FAIL rnd_beat%0d: got %h required %h", k, obs_data[k], {BE_W{ep[k]}}); end
    end
    vectors++;
    if (obs_hold_bad) begin miscompares++; $display("FAIL rnd_stall_hold: got outputs changing under waitrequest required held"); end
    pulse_done();
  endtask
  task automatic test_byteenable();
    cmp_struct_t c;
    logic [BE_W-1:0] eb[3];
    eb = '{8'hFC, 8'hFF, 8'h03};
    c = mk_cmd(32'h0000_3000, 0, 2, 1, FIX_DATA, 8'h3C);
    do_transfer(c, -1, 0, -1, 100);
    vectors++;
    if (obs_data.size() != 1 || obs_be[0] !== 8'h00 || obs_wr_burst !== 8'd1) begin
      miscompares++; $display("FAIL be_single: got beats=%0d be=%h bc=%0d required 1/00/1", obs_data.size(), obs_be[0], obs_wr_burst);
    end
    pulse_done();
    c.words_count = 2;
    do_transfer(c, -1, 0, -1, 100);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs_be[k] !== eb[k]) begin miscompares++; $display("FAIL be_multi%0d: got %h required %h", k, obs_be[k], eb[k]); end
    end
    pulse_done();
  endtask
  task automatic test_random();
    cmp_struct_t c;
    for (int n = 0; n < 10; n++) begin
      c = mk_cmd($urandom, WC_W'($urandom_range(0, 5)), OFF_W'($urandom_range(0, 7)), OFF_W'($urandom_range(0, 7)),
                 data_mode_t'($urandom_range(0, 1)), 8'($urandom_range(1, 255)));
      build_expected(c);
      do_transfer(c, $urandom_range(0, int'(c.words_count)), $urandom_range(0, 3), -1, 200);
      vectors++;
      if (obs_tmo || obs_data.size() != exp_data.size()) begin
        miscompares++; $display("FAIL rand%0d_beats: got %0d tmo=%0b required %0d", n, obs_data.size(), obs_tmo, exp_data.size());
      end
      for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
        vectors++;
        if (obs_data[k] !== exp_data[k] || obs_be[k] !== exp_be[k]) begin
          miscompares++; $display("FAIL rand%0d_beat%0d: got %h/%h required %h/%h", n, k, obs_data[k], obs_be[k], exp_data[k], exp_be[k]);
        end
      end
      vectors++;
      if (obs_addr !== c.start_addr || obs_rd_burst !== AMM_BURST_W'(exp_data.size()) || obs_cmp_en !== 1 || obs_cmp !== c) begin
        miscompares++; $display("FAIL rand%0d_read: got addr=%h bc=%0d cmp_en=%0d cmp=%h required %h/%0d/1/%h",
                                n, obs_addr, obs_rd_burst, obs_cmp_en, obs_cmp, c.start_addr, exp_data.size(), c);
      end
      pulse_done();
    end
  endtask
  task automatic test_credits();
    cmp_struct_t c;
    bit seen = 0;
    c = mk_cmd(32'h0000_4000, 1, 0, 7, FIX_DATA, 8'h5A);
    pulse_start();
    for (int n = 0; n < 4; n++) begin
      do_transfer(c, -1, 0, -1, 100);
      vectors++;
      if (obs_reads !== 1 || obs_tmo) begin miscompares++; $display("FAIL credit_read%0d: got reads=%0d tmo=%0b required 1/0", n, obs_reads, obs_tmo); end
    end
    do_transfer(c, -1, 0, -1, 40);
    vectors++;
    if (!obs_tmo || obs_reads !== 0 || obs_data.size() != 2 || trans_busy_o !== 1'b1) begin
      miscompares++; $display("FAIL credit_block: got tmo=%0b reads=%0d beats=%0d busy=%b required 1/0/2/1",
                              obs_tmo, obs_reads, obs_data.size(), trans_busy_o);
    end
    pulse_done();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i); seen = read_o;
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    vectors++;
    if (!seen || cmp_en_o !== 1'b1) begin miscompares++; $display("FAIL credit_release: got read=%0b cmp_en=%b required 1/1", seen, cmp_en_o); end
    @(posedge clk_i); #1;
  endtask
  task automatic test_async_reset();
    cmp_struct_t c;
    c = mk_cmd(32'h0000_5000, 5, 0, 7, RND_DATA, 8'h11);
    cmd_struct_i = c;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #3;
    vectors++;
    if (write_o !== 1'b1) begin miscompares++; $display("FAIL arst_pre_write: got %b required 1", write_o); end
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({write_o, read_o, cmp_en_o, trans_busy_o, cmd_ready_o} !== 5'b0 ||
        {address_o, writedata_o, byteenable_o, burstcount_o, cmp_struct_o} !== '0) begin
      miscompares++; $display("FAIL arst_outputs: got wr=%b busy=%b addr=%h data=%h bc=%h required all zero",
                              write_o, trans_busy_o, address_o, writedata_o, burstcount_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    do_transfer(mk_cmd(32'h0000_5100, 0, 0, 7, FIX_DATA, 8'h77), -1, 0, -1, 60);
    vectors++;
    if (obs_reads !== 1 || obs_tmo) begin miscompares++; $display("FAIL arst_credits_cleared: got reads=%0d tmo=%0b required 1/0", obs_reads, obs_tmo); end
    pulse_done();
  endtask
  task automatic test_error_stop();
    cmp_struct_t c;
    bit ready_seen = 0;
    c = mk_cmd(32'h0000_6000, 3, 0, 7, FIX_DATA, 8'hC3);
    pulse_start();
    do_transfer(c, -1, 0, 1, 100);
    vectors++;
    if (obs_tmo || obs_data.size() != 4 || obs_reads !== 0 || obs_cmp_en !== 0) begin
      miscompares++; $display("FAIL err_write: got tmo=%0b beats=%0d reads=%0d cmp_en=%0d required 0/4/0/0",
                              obs_tmo, obs_data.size(), obs_reads, obs_cmp_en);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); ready_seen |= cmd_ready_o | trans_busy_o | read_o | write_o;
      @(posedge clk_i); #1;
    end
    vectors++;
    if (ready_seen) begin miscompares++; $display("FAIL err_stop_hold: got activity in stop required none"); end
    pulse_start();
    @(negedge clk_i);
    vectors++;
    if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL err_restart: got ready=%b required 1", cmd_ready_o); end
    @(posedge clk_i); #1;
    do_transfer(c, -1, 0, -2, 100);
    @(negedge clk_i);
    vectors++;
    if (obs_reads !== 1 || obs_cmp_en !== 0 || cmd_ready_o !== 1'b0 || trans_busy_o !== 1'b0) begin
      miscompares++; $display("FAIL err_read: got reads=%0d cmp_en=%0d ready=%b busy=%b required 1/0/0/0",
                              obs_reads, obs_cmp_en, cmd_ready_o, trans_busy_o);
    end
    @(posedge clk_i); #1;
    pulse_start();
  endtask
  initial begin
    test_reset();
    test_fix_burst();
    test_rnd_stall();
    test_byteenable();
    test_random();
    test_credits();
    test_async_reset();
    test_error_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
